// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage between the PC block and decode.
// Issues in-order fetch requests at the current PC, pairs each returned
// instruction word with its PC and buffers the pairs in a DEPTH-entry queue.
// A slot is reserved when its request is accepted, so the queue doubles as the
// credit pool for outstanding memory requests. A flush (redirect) frees every
// slot and counts the still-outstanding responses so they can be discarded.
//
// Ports:
//   clk             clock, all state on the rising edge
//   rst             asynchronous active-low reset, released synchronously
//   pc_i            current PC from the PC block
//   flush           redirect: kill everything queued and in flight
//   pc_advance      request accepted this cycle, PC may step
//   imem_req_valid  fetch request valid
//   imem_req_ready  memory accepts the request
//   imem_addr       fetch address (equal to pc_i)
//   imem_resp_valid read data valid, in request order
//   imem_resp_data  instruction word
//   out_valid       head entry holds a complete instruction
//   out_ready       decode consumes the head entry
//   out_instr       head instruction
//   out_pc          PC of the head instruction
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_i,
  input  logic          flush,
  output logic          pc_advance,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_resp_valid,
  input  logic [DW-1:0] imem_resp_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_instr,
  output logic [AW-1:0] out_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_C     = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ZERO_C = (PW+1)'(0);
  localparam logic [PW:0]   CNT_ONE_C  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ZERO_C = PW'(0);
  localparam logic [PW-1:0] PTR_ONE_C  = PW'(1);
  localparam logic [PW+1:0] SUM_ONE_C  = (PW+2)'(1);

  logic [1:0]    rst_sync_r;
  logic          rst_n_s;

  logic [AW-1:0] slot_pc_r    [DEPTH];
  logic [DW-1:0] slot_instr_r [DEPTH];
  logic [DEPTH-1:0] slot_rsv_r;
  logic [DEPTH-1:0] slot_fil_r;

  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] fill_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   used_r;
  logic [PW:0]   rsv_cnt_r;
  logic [PW:0]   drop_r;

  logic          req_fire_s;
  logic          resp_drop_s;
  logic          resp_fill_s;
  logic          pop_s;
  logic [PW+1:0] drop_sum_s;
  logic [PW:0]   flush_drop_s;

  // Reset synchronizer: assertion is immediate, release follows two clock edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  // Request credit comes from the queue itself: a request needs a free slot.
  assign imem_req_valid = rst_n_s && (used_r < FULL_C) && !flush;
  assign imem_addr      = pc_i;
  assign req_fire_s     = imem_req_valid && imem_req_ready;
  assign pc_advance     = req_fire_s;

  // Stale responses (issued before a flush) are consumed first; otherwise the
  // data belongs to the oldest reserved slot. Anything else is ignored.
  assign resp_drop_s = imem_resp_valid && (drop_r != CNT_ZERO_C);
  assign resp_fill_s = imem_resp_valid && (drop_r == CNT_ZERO_C) && slot_rsv_r[fill_ptr_r];

  assign out_valid = slot_fil_r[rd_ptr_r];
  assign out_instr = slot_instr_r[rd_ptr_r];
  assign out_pc    = slot_pc_r[rd_ptr_r];
  assign pop_s     = out_valid && out_ready;

  // Outstanding-response count to discard after a flush. A response arriving
  // in the flush cycle itself is one of the outstanding ones (either already
  // owed to drop or headed for a reserved slot), so it is subtracted here.
  always_comb begin
    drop_sum_s = {1'b0, drop_r} + {1'b0, rsv_cnt_r};
    if (imem_resp_valid && ((drop_r != CNT_ZERO_C) || (rsv_cnt_r != CNT_ZERO_C))) begin
      drop_sum_s = drop_sum_s - SUM_ONE_C;
    end else begin
      drop_sum_s = drop_sum_s;
    end
    if (drop_sum_s > {1'b0, FULL_C}) begin
      flush_drop_s = FULL_C;
    end else begin
      flush_drop_s = drop_sum_s[PW:0];
    end
  end

  // Queue state: slot reservation, fill, pop and flush bookkeeping.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc_r[i]    <= '0;
        slot_instr_r[i] <= '0;
      end
      slot_rsv_r <= '0;
      slot_fil_r <= '0;
      wr_ptr_r   <= PTR_ZERO_C;
      fill_ptr_r <= PTR_ZERO_C;
      rd_ptr_r   <= PTR_ZERO_C;
      used_r     <= CNT_ZERO_C;
      rsv_cnt_r  <= CNT_ZERO_C;
      drop_r     <= CNT_ZERO_C;
    end else if (flush) begin
      slot_rsv_r <= '0;
      slot_fil_r <= '0;
      wr_ptr_r   <= PTR_ZERO_C;
      fill_ptr_r <= PTR_ZERO_C;
      rd_ptr_r   <= PTR_ZERO_C;
      used_r     <= CNT_ZERO_C;
      rsv_cnt_r  <= CNT_ZERO_C;
      drop_r     <= flush_drop_s;
    end else begin
      // Fire, fill and pop always target distinct slots (free, reserved and
      // filled respectively), so these updates never collide.
      if (req_fire_s) begin
        slot_pc_r[wr_ptr_r]  <= pc_i;
        slot_rsv_r[wr_ptr_r] <= 1'b1;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE_C;
      end
      if (resp_fill_s) begin
        slot_instr_r[fill_ptr_r] <= imem_resp_data;
        slot_rsv_r[fill_ptr_r]   <= 1'b0;
        slot_fil_r[fill_ptr_r]   <= 1'b1;
        fill_ptr_r               <= fill_ptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        slot_fil_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r             <= rd_ptr_r + PTR_ONE_C;
      end
      if (resp_drop_s) begin
        drop_r <= drop_r - CNT_ONE_C;
      end
      used_r    <= used_r + {{PW{1'b0}}, req_fire_s} - {{PW{1'b0}}, pop_s};
      rsv_cnt_r <= rsv_cnt_r + {{PW{1'b0}}, req_fire_s} - {{PW{1'b0}}, resp_fill_s};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, scoreboard-checked bench for fetch_queue.
// Responses that must reach decode push {pc, instr} into exp_q when issued;
// the monitor pops and compares whenever decode consumes the head entry.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        flush;
  logic        pc_advance;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q [$];
  logic [63:0] mon_e;

  logic [31:0] d2 [4] = '{32'h11111113, 32'h22222213, 32'h33333313, 32'h44444413};
  logic [31:0] d4 [4] = '{32'h55555593, 32'h66666693, 32'h77777793, 32'h88888893};

  fetch_queue #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_i            (pc_i),
    .flush           (flush),
    .pc_advance      (pc_advance),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every consumed head entry against the scoreboard.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got pc %h instr %h, expected no entry", out_pc, out_instr);
      end else begin
        mon_e = exp_q.pop_front();
        chk32("out_pc", out_pc, mon_e[63:32]);
        chk32("out_instr", out_instr, mon_e[31:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_req(input logic [31:0] pc);
    pc_i = pc;
    imem_req_ready = 1'b1;
    @(negedge clk);
    chk1("req_pc_advance", pc_advance, 1'b1);
    chk32("req_addr", imem_addr, pc);
    step();
    imem_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input bit keep, input logic [31:0] pc);
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    if (keep) exp_q.push_back({pc, data});
    step();
    imem_resp_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    chk32("drain_remaining", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; pc_i = 32'h0; flush = 1'b0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_pc_advance", pc_advance, 1'b0);
    chk32("rst_out_pc", out_pc, 32'h0);
    chk32("rst_out_instr", out_instr, 32'h0);
    @(posedge clk);
    #4 rst = 1'b1;
    step(); step(); step();
    chk1("req_valid_after_rst", imem_req_valid, 1'b1);

    // Scenario 1: single fetch, one-cycle response, presented the cycle after.
    out_ready = 1'b1;
    issue_req(32'hBFC00000);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h00500093;
    exp_q.push_back({32'hBFC00000, 32'h00500093});
    @(negedge clk);
    chk1("s1_single_pulse", pc_advance, 1'b0);
    chk1("s1_fill_latency", out_valid, 1'b0);
    step();
    imem_resp_valid = 1'b0;
    @(negedge clk);
    chk1("s1_out_valid", out_valid, 1'b1);
    step();
    wait_drain(4);
    @(negedge clk);
    chk1("s1_empty_after_pop", out_valid, 1'b0);
    step();

    // Scenario 2: fill to DEPTH, request blocked, pop re-enables one cycle later.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue_req(32'hBFC00000 + 32'(4 * i));
    for (int i = 0; i < 4; i++) respond(d2[i], 1'b1, 32'hBFC00000 + 32'(4 * i));
    pc_i = 32'hBFC00010;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk1("s2_full_req_valid", imem_req_valid, 1'b0);
    chk1("s2_full_no_advance", pc_advance, 1'b0);
    chk1("s2_full_out_valid", out_valid, 1'b1);
    step();
    out_ready = 1'b0;
    imem_req_ready = 1'b0;
    @(negedge clk);
    chk1("s2_req_after_pop", imem_req_valid, 1'b1);
    step();
    out_ready = 1'b1;
    wait_drain(10);

    // Scenario 3: flush with two requests outstanding; stale data discarded.
    issue_req(32'hBFC00040);
    issue_req(32'hBFC00044);
    flush = 1'b1;
    imem_req_ready = 1'b1;
    pc_i = 32'hBFC00100;
    @(negedge clk);
    chk1("s3_flush_req_valid", imem_req_valid, 1'b0);
    chk1("s3_flush_pc_advance", pc_advance, 1'b0);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk1("s3_out_valid_after_flush", out_valid, 1'b0);
    chk1("s3_resume_advance", pc_advance, 1'b1);
    chk32("s3_resume_addr", imem_addr, 32'hBFC00100);
    step();
    imem_req_ready = 1'b0;
    respond(32'hDEADBEEF, 1'b0, 32'h0);
    respond(32'hCAFEBABE, 1'b0, 32'h0);
    respond(32'h00A00113, 1'b1, 32'hBFC00100);
    wait_drain(4);

    // Scenario 4: full queue, pop and fill in the same cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue_req(32'hBFC00080 + 32'(4 * i));
    for (int i = 0; i < 3; i++) respond(d4[i], 1'b1, 32'hBFC00080 + 32'(4 * i));
    out_ready = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = d4[3];
    exp_q.push_back({32'hBFC0008C, d4[3]});
    @(negedge clk);
    chk1("s4_full_req_valid", imem_req_valid, 1'b0);
    chk1("s4_full_out_valid", out_valid, 1'b1);
    step();
    imem_resp_valid = 1'b0;
    wait_drain(10);
    @(negedge clk);
    chk1("s4_empty_out_valid", out_valid, 1'b0);
    chk1("s4_empty_req_valid", imem_req_valid, 1'b1);
    step();

    // Scenario 5: flush coinciding with a response and a request attempt.
    issue_req(32'hBFC00200);
    issue_req(32'hBFC00204);
    flush = 1'b1;
    step();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0BADF00D;
    imem_req_ready  = 1'b1;
    pc_i = 32'hBFC00300;
    @(negedge clk);
    chk1("s5_flush_resp_advance", pc_advance, 1'b0);
    chk1("s5_flush_resp_req_valid", imem_req_valid, 1'b0);
    step();
    flush = 1'b0;
    imem_resp_valid = 1'b0;
    @(negedge clk);
    chk1("s5_resume_advance", pc_advance, 1'b1);
    step();
    imem_req_ready = 1'b0;
    respond(32'h0BADCAFE, 1'b0, 32'h0);
    respond(32'h00300193, 1'b1, 32'hBFC00300);
    wait_drain(4);

    // Scenario 6: asynchronous reset mid-stream, then a clean first fetch.
    out_ready = 1'b0;
    issue_req(32'hBFC00400);
    respond(32'h00400213, 1'b1, 32'hBFC00400);
    issue_req(32'hBFC00404);
    @(posedge clk);
    #3;
    imem_req_ready = 1'b1;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk1("s6_rst_out_valid", out_valid, 1'b0);
    chk1("s6_rst_req_valid", imem_req_valid, 1'b0);
    chk1("s6_rst_pc_advance", pc_advance, 1'b0);
    chk32("s6_rst_out_pc", out_pc, 32'h0);
    chk32("s6_rst_out_instr", out_instr, 32'h0);
    @(posedge clk);
    #4;
    rst = 1'b1;
    imem_req_ready = 1'b0;
    step(); step(); step();
    respond(32'h12345678, 1'b0, 32'h0);
    out_ready = 1'b1;
    issue_req(32'hBFC00000);
    respond(32'h00500093, 1'b1, 32'hBFC00000);
    wait_drain(4);
    @(negedge clk);
    chk1("s6_empty_after_pop", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
